// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout brick map: geometry, entry bit layout,
// game-engine opcodes and the brick-map arbiter state encoding.
package breakout_pkg;

    localparam int ROWS     = 5;
    localparam int COLS     = 12;
    localparam int N_BRICKS = ROWS * COLS;

    // Entry layout: {color, hit}
    localparam int HIT_BIT   = 0;
    localparam int COLOR_BIT = 1;

    localparam logic [1:0] GM_OP_READ  = 2'b00;
    localparam logic [1:0] GM_OP_WRITE = 2'b01;
    localparam logic [1:0] GM_OP_TAS   = 2'b10;
    localparam logic [1:0] GM_OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ARB_INIT   = 2'd0,
        ARB_IDLE   = 2'd1,
        ARB_RMW_WR = 2'd2
    } arb_state_e;

endpackage

// File: rtl/brick_state_ram.sv
// Single-port brick-state array, 2 bits per entry, synchronous read.
// A write returns the previous contents of the addressed entry (read-first).
module brick_state_ram #(
    parameter int DEPTH  = 60,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [1:0]        i_wdata,
    output logic [1:0]        o_rdata
);

    logic [1:0] r_mem [DEPTH];
    logic [1:0] r_rdata;

    // Read-first single-port access.
    // NOTE: the array and its read register have no reset: a RAM macro has none,
    // and the initialisation sweep is what gives every entry a defined value.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/brick_map_arbiter.sv
// Brick map owner: arbitrates the single RAM port between the VGA renderer and
// the game engine, runs the initialisation sweep, and counts unhit bricks.
module brick_map_arbiter
    import breakout_pkg::*;
#(
    parameter int ROWS         = breakout_pkg::ROWS,
    parameter int COLS         = breakout_pkg::COLS,
    parameter int ADDR_W       = 6,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_req,
    output logic              init_busy,
    input  logic              ren_req,
    input  logic [ADDR_W-1:0] ren_addr,
    output logic              ren_valid,
    output logic [1:0]        ren_rdata,
    input  logic              gm_req,
    input  logic [1:0]        gm_op,
    input  logic [ADDR_W-1:0] gm_addr,
    input  logic [1:0]        gm_wdata,
    output logic              gm_done,
    output logic [1:0]        gm_rdata,
    output logic              gm_err,
    output logic [ADDR_W-1:0] bricks_left,
    output logic              all_clear
);

    localparam int                N      = ROWS * COLS;
    localparam logic [ADDR_W-1:0] N_A    = ADDR_W'(N);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(N - 1);
    localparam int                CW     = $clog2(COLS);
    localparam logic [CW-1:0]     COL_LAST = CW'(COLS - 1);
    localparam int                SW     = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]     STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_e        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_sweep;
    logic [CW-1:0]     r_col;
    logic              r_row_odd;
    logic              r_init_busy;
    logic [SW-1:0]     r_starve;
    logic              r_gm_done, r_gm_err, r_gm_wr_hit;
    logic [1:0]        r_gm_op;
    logic [ADDR_W-1:0] r_gm_addr;
    logic              r_ren_valid, r_ren_oor;
    logic [ADDR_W-1:0] r_bricks;
    logic              r_all_clear;

    logic              w_ram_en, w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [1:0]        w_ram_wdata, w_ram_rdata;
    logic              w_gm_pend, w_gm_oor, w_ren_oor, w_gm_is_tas, w_gm_is_write;
    logic              w_gm_grant, w_ren_grant, w_sweep_done;
    logic              w_done_live, w_old_hit, w_cnt_dec, w_cnt_inc;

    brick_state_ram #(.DEPTH(N), .ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Request qualification and brick-count deltas from the completing game op.
    always_comb begin
        w_gm_oor     = (gm_addr >= N_A);
        w_ren_oor    = (ren_addr >= N_A);
        // A held gm_req during its own gm_done cycle is the finishing request, not a new one.
        w_gm_pend    = gm_req && !r_gm_done;
        w_sweep_done = (r_state == ARB_INIT) && !init_req && (r_sweep == LAST_A);
        w_gm_is_tas   = 1'b0;
        w_gm_is_write = 1'b0;
        case (gm_op)
            GM_OP_WRITE:             w_gm_is_write = 1'b1;
            GM_OP_TAS:               w_gm_is_tas   = 1'b1;
            GM_OP_READ, GM_OP_RSVD:  ;
            default:                 ;
        endcase
        // The RAM read register holds the pre-operation entry in the gm_done cycle,
        // including after the RMW write, since the RAM is read-first.
        w_done_live = r_gm_done && !r_gm_err;
        w_old_hit   = w_ram_rdata[HIT_BIT];
        w_cnt_dec   = w_done_live && !w_old_hit && (r_bricks != '0) &&
                      ((r_gm_op == GM_OP_TAS) || ((r_gm_op == GM_OP_WRITE) && r_gm_wr_hit));
        w_cnt_inc   = w_done_live && w_old_hit && (r_bricks != N_A) &&
                      (r_gm_op == GM_OP_WRITE) && !r_gm_wr_hit;
    end

    // Next-state, arbitration and RAM port steering.
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nxt = r_state;
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = '0;
        w_ram_wdata = '0;
        w_gm_grant  = 1'b0;
        w_ren_grant = 1'b0;
        case (r_state)
            ARB_INIT: begin
                w_ram_en   = 1'b1;
                w_ram_we   = 1'b1;
                w_ram_addr = r_sweep;
                w_ram_wdata[COLOR_BIT] = r_row_odd ^ r_col[0];
                if (w_sweep_done) w_state_nxt = ARB_IDLE;
            end
            ARB_IDLE: begin
                if (init_req) begin
                    w_state_nxt = ARB_INIT;
                end else if (w_gm_pend && (!ren_req || (r_starve == STARVE_MAX))) begin
                    w_gm_grant = 1'b1;
                    if (!w_gm_oor) begin
                        w_ram_en    = 1'b1;
                        w_ram_we    = w_gm_is_write;
                        w_ram_addr  = gm_addr;
                        w_ram_wdata = gm_wdata;
                        if (w_gm_is_tas) w_state_nxt = ARB_RMW_WR;
                    end
                end else if (ren_req) begin
                    w_ren_grant = 1'b1;
                    if (!w_ren_oor) begin
                        w_ram_en   = 1'b1;
                        w_ram_addr = ren_addr;
                    end
                end
            end
            ARB_RMW_WR: begin
                w_ram_en    = 1'b1;
                w_ram_we    = 1'b1;
                w_ram_addr  = r_gm_addr;
                w_ram_wdata = w_ram_rdata;
                w_ram_wdata[HIT_BIT] = 1'b1;
                w_state_nxt = init_req ? ARB_INIT : ARB_IDLE;
            end
            default: w_state_nxt = ARB_INIT;
        endcase
    end

    // State register; the sweep flag mirrors "next state is INIT".
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_INIT;
            r_init_busy <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_init_busy <= (w_state_nxt == ARB_INIT);
        end
    end

    // Sweep address with row parity and column tracked alongside to form the color.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sweep   <= '0;
            r_col     <= '0;
            r_row_odd <= 1'b0;
        end else if ((r_state == ARB_INIT) && !init_req && (r_sweep != LAST_A)) begin
            r_sweep <= r_sweep + 1'b1;
            if (r_col == COL_LAST) begin
                r_col     <= '0;
                r_row_odd <= ~r_row_odd;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end else begin
            r_sweep   <= '0;
            r_col     <= '0;
            r_row_odd <= 1'b0;
        end
    end

    // Starve counter, in-flight game operation and renderer response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve    <= '0;
            r_gm_done   <= 1'b0;
            r_gm_err    <= 1'b0;
            r_gm_wr_hit <= 1'b0;
            r_gm_op     <= GM_OP_READ;
            r_gm_addr   <= '0;
            r_ren_valid <= 1'b0;
            r_ren_oor   <= 1'b0;
        end else begin
            if (w_gm_grant || (r_state != ARB_IDLE)) begin
                r_starve <= '0;
            end else if (w_ren_grant && w_gm_pend && (r_starve != STARVE_MAX)) begin
                r_starve <= r_starve + 1'b1;
            end
            r_gm_done <= (w_gm_grant && !(w_gm_is_tas && !w_gm_oor)) || (r_state == ARB_RMW_WR);
            if (w_gm_grant) begin
                r_gm_err    <= w_gm_oor;
                r_gm_op     <= gm_op;
                r_gm_addr   <= gm_addr;
                r_gm_wr_hit <= gm_wdata[HIT_BIT];
            end
            r_ren_valid <= w_ren_grant;
            r_ren_oor   <= w_ren_grant && w_ren_oor;
        end
    end

    // Remaining-brick counter and the 1 -> 0 all-clear pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bricks    <= '0;
            r_all_clear <= 1'b0;
        end else begin
            r_all_clear <= 1'b0;
            if (w_sweep_done) begin
                r_bricks <= N_A;
            end else if (w_cnt_dec) begin
                r_bricks    <= r_bricks - 1'b1;
                r_all_clear <= (r_bricks == ADDR_W'(1));
            end else if (w_cnt_inc) begin
                r_bricks <= r_bricks + 1'b1;
            end
        end
    end

    assign init_busy   = r_init_busy;
    assign ren_valid   = r_ren_valid;
    assign ren_rdata   = r_ren_valid ? (r_ren_oor ? 2'b01 : w_ram_rdata) : 2'b00;
    assign gm_done     = r_gm_done;
    assign gm_err      = r_gm_done && r_gm_err;
    assign gm_rdata    = r_gm_done ? (r_gm_err ? 2'b01 : w_ram_rdata) : 2'b00;
    assign bricks_left = r_bricks;
    assign all_clear   = r_all_clear;

endmodule
